// File: rtl/jt900h_fetch.sv
// Prefetch queue for the TLCS-900H core: keeps up to 8 opcode bytes ahead of pc,
// fetching 16-bit words from the bus and tolerating odd start addresses.
module jt900h_fetch #(
  parameter logic [23:0] RSTPC = 24'hFF0000
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        pc_ld,
  input  logic [23:0] pc_new,
  input  logic        inc_pc,
  output logic [23:0] bus_addr,
  output logic        bus_rd,
  input  logic [15:0] bus_din,
  input  logic        bus_ack,
  output logic [7:0]  md,
  output logic [31:0] win,
  output logic [3:0]  cnt,
  output logic [23:0] pc,
  output logic        mem_busy
);

  logic [7:0]  q [0:7];
  logic [7:0]  q_next [0:7];
  logic [23:0] fa, fa_next;
  logic [3:0]  cnt_next, base;
  logic        drop;
  logic        ack_ok, inc_ok, req_ok;

  assign ack_ok   = cen & bus_rd & bus_ack;
  assign inc_ok   = inc_pc & (cnt != 4'd0);
  // Requests only when a full word fits, so the queue can never overflow.
  assign req_ok   = ~bus_rd & ~pc_ld & (cnt <= 4'd6);
  assign mem_busy = (cnt == 4'd0);
  assign md       = q[0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_win
      assign win[gi*8 +: 8] = q[gi+1];
    end
  endgenerate

  // Shift first, then append incoming bytes behind the surviving entries.
  always_comb begin
    for (int i = 0; i < 8; i++) q_next[i] = q[i];
    base     = cnt;
    cnt_next = cnt;
    fa_next  = fa;
    if (inc_ok) begin
      for (int i = 0; i < 7; i++) q_next[i] = q[i+1];
      q_next[7] = 8'd0;
      base      = cnt - 4'd1;
      cnt_next  = base;
    end
    if (ack_ok && !drop) begin
      if (fa[0]) begin
        for (int i = 0; i < 8; i++)
          if (4'(i) == base) q_next[i] = bus_din[15:8];
        cnt_next = base + 4'd1;
        fa_next  = fa + 24'd1;
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (4'(i) == base)         q_next[i] = bus_din[7:0];
          if (4'(i) == base + 4'd1)  q_next[i] = bus_din[15:8];
        end
        cnt_next = base + 4'd2;
        fa_next  = fa + 24'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RSTPC;
      fa       <= RSTPC;
      cnt      <= 4'd0;
      for (int i = 0; i < 8; i++) q[i] <= 8'd0;
      bus_rd   <= 1'b0;
      bus_addr <= {RSTPC[23:1], 1'b0};
      drop     <= 1'b0;
    end else if (cen) begin
      if (pc_ld) begin
        pc  <= pc_new;
        fa  <= pc_new;
        cnt <= 4'd0;
        for (int i = 0; i < 8; i++) q[i] <= 8'd0;
        // An in-flight read must still complete on the bus; its data is discarded.
        if (bus_rd) begin
          drop   <= ~bus_ack;
          bus_rd <= ~bus_ack;
        end
      end else begin
        pc  <= pc + {23'd0, inc_ok};
        fa  <= fa_next;
        cnt <= cnt_next;
        for (int i = 0; i < 8; i++) q[i] <= q_next[i];
        if (ack_ok) begin
          bus_rd <= 1'b0;
          drop   <= 1'b0;
        end else if (req_ok) begin
          bus_rd   <= 1'b1;
          bus_addr <= {fa[23:1], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_jt900h_fetch.sv
// Scoreboard bench for jt900h_fetch: bytes are queued as the bench acks reads and
// compared as the queue is consumed; directed sequences cover reset, odd PC, flush and wrap.
module tb_jt900h_fetch;
  localparam logic [23:0] RSTPC = 24'hFF0000;

  logic        rst, clk, cen, pc_ld, inc_pc, bus_rd, bus_ack, mem_busy;
  logic [23:0] pc_new, bus_addr, pc;
  logic [15:0] bus_din;
  logic [7:0]  md;
  logic [31:0] win;
  logic [3:0]  cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb[$];
  logic [23:0] m_pc, m_fa;
  logic        m_drop;

  jt900h_fetch #(.RSTPC(RSTPC)) dut (
    .rst(rst), .clk(clk), .cen(cen), .pc_ld(pc_ld), .pc_new(pc_new), .inc_pc(inc_pc),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_din(bus_din), .bus_ack(bus_ack),
    .md(md), .win(win), .cnt(cnt), .pc(pc), .mem_busy(mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] memb(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  function automatic logic [15:0] memw(input logic [23:0] a);
    logic [23:0] b;
    b = {a[23:1], 1'b0};
    return {memb(b + 24'd1), memb(b)};
  endfunction

  // One clock: drive inputs, advance, update the model, compare visible state.
  task automatic cyc(input logic ld, input logic [23:0] nw, input logic inc,
                     input logic ack, input logic [15:0] din);
    logic        acc, rd0;
    logic [31:0] ew;
    logic [7:0]  emd;
    pc_ld = ld; pc_new = nw; inc_pc = inc; bus_ack = ack; bus_din = din;
    rd0 = bus_rd;
    acc = cen && ack && rd0;
    if (cen && !ld && inc && sb.size() > 0) begin
      check("md_pop", {24'd0, md}, {24'd0, sb[0]});
      check("pc_pop", {8'd0, pc}, {8'd0, m_pc});
    end
    if (acc && !m_drop && !ld) check("addr", {8'd0, bus_addr}, {8'd0, m_fa[23:1], 1'b0});
    @(posedge clk); #1;
    pc_ld = 1'b0; inc_pc = 1'b0; bus_ack = 1'b0;
    if (cen) begin
      if (ld) begin
        m_pc = nw; m_fa = nw; sb.delete();
        if (rd0) m_drop = !ack;
      end else begin
        if (inc && sb.size() > 0) begin
          void'(sb.pop_front());
          m_pc = m_pc + 24'd1;
        end
        if (acc) begin
          if (m_drop) m_drop = 1'b0;
          else if (m_fa[0]) begin
            sb.push_back(din[15:8]); m_fa = m_fa + 24'd1;
          end else begin
            sb.push_back(din[7:0]); sb.push_back(din[15:8]); m_fa = m_fa + 24'd2;
          end
        end
      end
    end
    ew = 32'd0;
    for (int k = 1; k <= 4; k++) if (k < sb.size()) ew[(k-1)*8 +: 8] = sb[k];
    emd = (sb.size() > 0) ? sb[0] : 8'd0;
    check("cnt", {28'd0, cnt}, sb.size());
    check("pc", {8'd0, pc}, {8'd0, m_pc});
    check("md", {24'd0, md}, {24'd0, emd});
    check("win", win, ew);
    check("busy", {31'd0, mem_busy}, {31'd0, sb.size() == 0});
    check("rd_full", {31'd0, bus_rd && cnt >= 4'd7}, 32'd0);
    check("addr0", {31'd0, bus_addr[0]}, 32'd0);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus_rd && n < 50) begin
      cyc(1'b0, 24'd0, 1'b0, 1'b0, 16'd0);
      n++;
    end
    check({tag, "_req"}, {31'd0, bus_rd}, 32'd1);
  endtask

  task automatic idle_bus();
    int n = 0;
    while (bus_rd && n < 20) begin
      cyc(1'b0, 24'd0, 1'b0, 1'b1, memw(bus_addr));
      n++;
    end
    check("idle_bus", {31'd0, bus_rd}, 32'd0);
  endtask

  task automatic ack_now();
    cyc(1'b0, 24'd0, 1'b0, 1'b1, memw(bus_addr));
  endtask

  initial begin
    logic [23:0] exp40 [0:3];
    int acks;
    exp40[0] = 24'hFFFFFE; exp40[1] = 24'hFFFFFF; exp40[2] = 24'h000000; exp40[3] = 24'h000001;
    rst = 1'b1; cen = 1'b1; pc_ld = 1'b0; pc_new = 24'd0; inc_pc = 1'b0;
    bus_ack = 1'b0; bus_din = 16'd0;
    m_pc = RSTPC; m_fa = RSTPC; m_drop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd", {31'd0, bus_rd}, 32'd0);
    check("rst_cnt", {28'd0, cnt}, 32'd0);
    check("rst_pc", {8'd0, pc}, {8'd0, RSTPC});
    check("rst_busy", {31'd0, mem_busy}, 32'd1);
    check("rst_addr", {8'd0, bus_addr}, 32'h00FF0000);
    check("rst_md", {24'd0, md}, 32'd0);
    check("rst_win", win, 32'd0);
    rst = 1'b0;

    // First request on the first cen cycle after reset, then a 2-byte fill.
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 16'd0);
    check("r35_rd", {31'd0, bus_rd}, 32'd1);
    check("r35_addr", {8'd0, bus_addr}, 32'h00FF0000);
    cyc(1'b0, 24'd0, 1'b0, 1'b1, 16'h3412);
    check("r35_md", {24'd0, md}, 32'h12);
    check("r35_win", {24'd0, win[7:0]}, 32'h34);
    check("r35_cnt", {28'd0, cnt}, 32'd2);
    check("r35_pc", {8'd0, pc}, 32'h00FF0000);
    check("r35_busy", {31'd0, mem_busy}, 32'd0);

    // Odd jump target: only the high byte of the first word is used.
    cyc(1'b1, 24'h001235, 1'b0, 1'b0, 16'd0);
    check("r36_cnt0", {28'd0, cnt}, 32'd0);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 16'd0);
    check("r36_rd", {31'd0, bus_rd}, 32'd1);
    check("r36_addr", {8'd0, bus_addr}, 32'h00001234);
    cyc(1'b0, 24'd0, 1'b0, 1'b1, 16'hAB99);
    check("r36_md", {24'd0, md}, 32'hAB);
    check("r36_cnt", {28'd0, cnt}, 32'd1);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 16'd0);
    check("r36_addr2", {8'd0, bus_addr}, 32'h00001236);

    // Consume while a 2-byte ack lands with cnt=3.
    ack_now();
    check("r38_cnt3", {28'd0, cnt}, 32'd3);
    wait_req("r38");
    cyc(1'b0, 24'd0, 1'b1, 1'b1, memw(bus_addr));
    check("r38_cnt", {28'd0, cnt}, 32'd4);
    check("r38_pc", {8'd0, pc}, 32'h00001236);

    // Zero-stall acks without consumption stop once the queue is nearly full.
    cyc(1'b1, 24'h000200, 1'b0, 1'b0, 16'd0);
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_rd) acks++;
      cyc(1'b0, 24'd0, 1'b0, bus_rd, memw(bus_addr));
    end
    check("r37_cnt", {28'd0, cnt}, 32'd8);
    check("r37_acks", acks, 32'd4);
    check("r37_rd", {31'd0, bus_rd}, 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 24'd0, 1'b1, bus_rd, memw(bus_addr));

    // Jump while a read is in flight: the read completes and is discarded.
    idle_bus();
    cyc(1'b1, 24'h000040, 1'b0, 1'b0, 16'd0);
    wait_req("r39");
    check("r39_addr", {8'd0, bus_addr}, 32'h00000040);
    cyc(1'b1, 24'h000100, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 24'd0, 1'b0, 1'b0, 16'd0);
      check("r39_hold_rd", {31'd0, bus_rd}, 32'd1);
      check("r39_hold_addr", {8'd0, bus_addr}, 32'h00000040);
    end
    ack_now();
    check("r39_cnt", {28'd0, cnt}, 32'd0);
    check("r39_rd0", {31'd0, bus_rd}, 32'd0);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 16'd0);
    check("r39_addr2", {8'd0, bus_addr}, 32'h00000100);

    // Two jumps while one read is pending.
    cyc(1'b1, 24'h000300, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 24'h000400, 1'b0, 1'b0, 16'd0);
    check("r29_pc", {8'd0, pc}, 32'h00000400);
    check("r29_hold", {8'd0, bus_addr}, 32'h00000100);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 16'd0);
    ack_now();
    check("r29_cnt", {28'd0, cnt}, 32'd0);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 16'd0);
    check("r29_addr", {8'd0, bus_addr}, 32'h00000400);

    // Address wrap at the top of the 24-bit space.
    idle_bus();
    cyc(1'b1, 24'hFFFFFE, 1'b0, 1'b0, 16'd0);
    wait_req("r40a");
    check("r40_addr1", {8'd0, bus_addr}, 32'h00FFFFFE);
    ack_now();
    wait_req("r40b");
    check("r40_addr2", {8'd0, bus_addr}, 32'h00000000);
    ack_now();
    check("r40_cnt", {28'd0, cnt}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("r40_pc", {8'd0, pc}, {8'd0, exp40[i]});
      cyc(1'b0, 24'd0, 1'b1, 1'b0, 16'd0);
    end

    // Reset during a read; a late ack afterwards must be ignored.
    wait_req("r34");
    rst = 1'b1;
    #1;
    check("r34_rd_async", {31'd0, bus_rd}, 32'd0);
    check("r34_cnt_async", {28'd0, cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus_ack = 1'b1; bus_din = 16'hFFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("r34_cnt", {28'd0, cnt}, 32'd0);
    check("r34_rd", {31'd0, bus_rd}, 32'd1);
    check("r34_addr", {8'd0, bus_addr}, 32'h00FF0000);
    check("r34_pc", {8'd0, pc}, 32'h00FF0000);
    sb.delete(); m_pc = RSTPC; m_fa = RSTPC; m_drop = 1'b0;

    // Random traffic with clock-enable gaps, random stalls and occasional jumps.
    for (int i = 0; i < 3000; i++) begin
      logic        r_ld, r_inc, r_ack;
      logic [23:0] r_nw;
      cen   = ($urandom_range(0, 3) != 0);
      r_ld  = ($urandom_range(0, 49) == 0);
      r_nw  = 24'($urandom);
      r_inc = ($urandom_range(0, 1) == 1);
      r_ack = bus_rd && ($urandom_range(0, 1) == 1);
      cyc(r_ld, r_nw, r_inc, r_ack, memw(bus_addr));
    end
    cen = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt900h_fetch.md
JT900H_FETCH -- requirements
Module: jt900h_fetch

Interface
REQ-001 SHALL have parameter RSTPC, default 24'hFF0000, meaning the PC loaded at reset.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port cen  input  1  clock enable; all state advances only on clk edges with cen=1.
REQ-005 SHALL have port pc_ld  input  1  load new PC and flush the queue.
REQ-006 SHALL have port pc_new  input  24  target PC for pc_ld.
REQ-007 SHALL have port inc_pc  input  1  consume one byte from the queue head.
REQ-008 SHALL have port bus_addr  output  24  word-aligned read address, bit 0 always 0.
REQ-009 SHALL have port bus_rd  output  1  read request.
REQ-010 SHALL have port bus_din  input  16  read data, little-endian, valid with bus_ack.
REQ-011 SHALL have port bus_ack  input  1  read completion strobe.
REQ-012 SHALL have port md  output  8  queue head byte (opcode byte fed to the controller).
REQ-013 SHALL have port win  output  32  queue bytes 1..4, byte 1 in bits 7:0.
REQ-014 SHALL have port cnt  output  4  number of valid queued bytes, 0..8.
REQ-015 SHALL have port pc  output  24  address of the byte on md.
REQ-016 SHALL have port mem_busy  output  1  high while cnt==0.

Function
REQ-017 SHALL hold an 8-byte FIFO queue; md = entry 0; win = entries 1..4; entries at or beyond cnt SHALL read as 0.
REQ-018 SHALL keep an internal 24-bit fetch address fa: the byte address of the next byte to be enqueued.
REQ-019 SHALL assert bus_rd with bus_addr={fa[23:1],1'b0} when no read is outstanding, pc_ld=0, and free slots (8-cnt) >= 2.
REQ-020 SHALL keep bus_rd and bus_addr stable from assertion until the cen cycle on which bus_ack=1; bus_ack is ignored on cycles with cen=0.
REQ-021 On an accepted ack with fa[0]=0, SHALL enqueue bus_din[7:0] then bus_din[15:8] and advance fa by 2.
REQ-022 On an accepted ack with fa[0]=1, SHALL enqueue only bus_din[15:8] and advance fa by 1.
REQ-023 bus_rd MAY be re-asserted on the cycle after an ack; minimum request-to-request spacing is one cen cycle.
REQ-024 inc_pc with cnt>=1 SHALL shift the queue by one byte and advance pc by 1; inc_pc with cnt==0 SHALL be ignored.
REQ-025 Enqueue and inc_pc in the same cycle SHALL both take effect: new cnt = cnt + bytes_in - 1.
REQ-026 pc and fa SHALL wrap modulo 2^24 (24'hFFFFFF + 1 = 24'h000000).
REQ-027 pc_ld SHALL set pc<=pc_new, fa<=pc_new, cnt<=0, and take priority over inc_pc and over any ack in the same cycle.
REQ-028 If a read is outstanding at pc_ld, SHALL keep bus_rd/bus_addr unchanged until its ack and discard that data (drop state); the next request then uses the new fa.
REQ-029 A second pc_ld during drop SHALL update pc/fa again and keep drop set until the pending ack.
REQ-030 mem_busy SHALL equal (cnt==0), combinationally from registered cnt.
REQ-031 Queue overflow SHALL be impossible by construction (REQ-019); cnt never exceeds 8.

Reset
REQ-032 On rst: pc=RSTPC, fa=RSTPC, cnt=0, queue entries=0, bus_rd=0, drop=0, mem_busy=1; bus_addr={RSTPC[23:1],1'b0}.
REQ-033 The first request SHALL be issued on the first cen cycle after rst deasserts.
REQ-034 rst mid-read SHALL abandon the read; a late bus_ack after reset SHALL be treated as belonging to no request and ignored.

Verification
REQ-035 Reset with RSTPC=24'hFF0000, ack data 16'h3412 -> bus_addr=24'hFF0000, then md=8'h12, win[7:0]=8'h34, cnt=2, pc=24'hFF0000, mem_busy=0.
REQ-036 pc_ld with pc_new=24'h001235 (odd), ack data 16'hAB99 -> bus_addr=24'h001234, md=8'hAB, cnt=1, next bus_addr=24'h001236.
REQ-037 Ack with zero stall, never inc_pc -> requests stop once cnt=7 or 8 (free<2); bus_rd stays 0 while cnt>=7.
REQ-038 inc_pc on the same cen cycle as a 2-byte ack with cnt=3 -> cnt=4, pc+1.
REQ-039 pc_ld to 24'h000100 while a read to 24'h000040 is outstanding -> bus_addr holds 24'h000040 until ack, data dropped, cnt=0, next bus_addr=24'h000100.
REQ-040 pc_ld to 24'hFFFFFE, two 2-byte acks -> second bus_addr=24'h000000; with four inc_pc, pc steps FFFFFE, FFFFFF, 000000, 000001.
